// File: rtl/sw_hist_disp_if.sv
// Board-side bundle for sw_hist_disp: raw switches and freeze in, scanned 7-seg and LEDs out.
// The master drives the switches; the display block is the slave.
interface sw_hist_disp_if #(
    parameter int unsigned SW_W   = 4,
    parameter int unsigned DIGITS = 4
) ();
    logic [SW_W-1:0]   switch;
    logic              freeze;
    logic [DIGITS-1:0] num_csn;
    logic [6:0]        num_a_g;
    logic [SW_W-1:0]   led;

    modport master (
        output switch,
        output freeze,
        input  num_csn,
        input  num_a_g,
        input  led
    );

    modport slave (
        input  switch,
        input  freeze,
        output num_csn,
        output num_a_g,
        output led
    );
endinterface

// File: rtl/sw_hist_disp.sv
// Switch-history display: debounces an active-low switch bank, keeps a DIGITS-deep history
// of committed values and scans it newest-first onto a multiplexed 7-segment display.
module sw_hist_disp #(
    parameter int unsigned SW_W      = 4,
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned SCAN_DIV  = 1000
) (
    input logic           clk,
    input logic           resetn,
    sw_hist_disp_if.slave disp_io
);

    localparam int unsigned DcntW = $clog2(DB_CYCLES + 1);
    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW  = $clog2(DIGITS);

    localparam logic [DcntW-1:0] DcntLast = DcntW'(DB_CYCLES - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DIGITS - 1);

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'ha: s = 7'b1110111;
            4'hb: s = 7'b0011111;
            4'hc: s = 7'b1001110;
            4'hd: s = 7'b0111101;
            4'he: s = 7'b1001111;
            4'hf: s = 7'b1000111;
        endcase
        return s;
    endfunction

    logic [SW_W-1:0]         sw_n_q;
    logic [SW_W-1:0]         cand_q, cand_d;
    logic [DcntW-1:0]        dcnt_q, dcnt_d;
    logic [SW_W-1:0]         cur_q, cur_d;
    logic [DIGITS-1:0][3:0]  hist_q, hist_d;
    logic [DIGITS-1:0]       hv_q, hv_d;
    logic [ScanW-1:0]        scnt_q, scnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [DIGITS-1:0]       csn_q, csn_d;
    logic [6:0]              seg_q, seg_d;
    logic [SW_W-1:0]         led_q, led_d;

    logic       commit;
    logic [3:0] cand_hex;

    // A value commits only once it has been seen unchanged for DB_CYCLES+1 samples.
    assign commit   = (cand_q == sw_n_q) && (dcnt_q == DcntLast) && (cand_q != cur_q);
    assign cand_hex = 4'(cand_q);

    always_comb begin
        cand_d = cand_q;
        dcnt_d = dcnt_q;
        if (sw_n_q != cand_q) begin
            cand_d = sw_n_q;
            dcnt_d = '0;
        end else if (dcnt_q < DcntLast) begin
            dcnt_d = dcnt_q + DcntW'(1);
        end
    end

    // Freeze only blocks the history shift; cur keeps tracking so no catch-up on release.
    always_comb begin
        cur_d  = cur_q;
        hist_d = hist_q;
        hv_d   = hv_q;
        if (commit) begin
            cur_d = cand_q;
            if (!disp_io.freeze) begin
                hist_d = {hist_q[DIGITS-2:0], cand_hex};
                hv_d   = {hv_q[DIGITS-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        scnt_d = scnt_q + ScanW'(1);
        idx_d  = idx_q;
        if (scnt_q == ScanLast) begin
            scnt_d = '0;
            idx_d  = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
    end

    // Outputs are built from pre-edge state, so a commit shows up one clock later.
    always_comb begin
        csn_d = ~(DIGITS'(1) << idx_q);
        seg_d = hv_q[idx_q] ? seg7(hist_q[idx_q]) : 7'b0000000;
        led_d = hv_q[1] ? ~hist_q[1][SW_W-1:0] : '1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sw_n_q <= '0;
            cand_q <= '0;
            dcnt_q <= '0;
            cur_q  <= '0;
            hist_q <= '0;
            hv_q   <= '0;
            scnt_q <= '0;
            idx_q  <= '0;
            csn_q  <= '1;
            seg_q  <= '0;
            led_q  <= '1;
        end else begin
            sw_n_q <= ~disp_io.switch;
            cand_q <= cand_d;
            dcnt_q <= dcnt_d;
            cur_q  <= cur_d;
            hist_q <= hist_d;
            hv_q   <= hv_d;
            scnt_q <= scnt_d;
            idx_q  <= idx_d;
            csn_q  <= csn_d;
            seg_q  <= seg_d;
            led_q  <= led_d;
        end
    end

    assign disp_io.num_csn = csn_q;
    assign disp_io.num_a_g = seg_q;
    assign disp_io.led     = led_q;

endmodule

// File: tb/tb_sw_hist_disp.sv
// Scoreboard bench for sw_hist_disp: the driver pushes expected outputs from a reference model,
// and a monitor pops and compares them one clock later.
module tb_sw_hist_disp;

    localparam int unsigned SW_W      = 4;
    localparam int unsigned DIGITS    = 4;
    localparam int unsigned DB_CYCLES = 3;
    localparam int unsigned SCAN_DIV  = 2;

    typedef struct {
        logic [DIGITS-1:0] csn;
        logic [6:0]        seg;
        logic [SW_W-1:0]   led;
    } exp_t;

    logic clk;
    logic resetn;

    sw_hist_disp_if #(.SW_W(SW_W), .DIGITS(DIGITS)) dif ();

    sw_hist_disp #(
        .SW_W      (SW_W),
        .DIGITS    (DIGITS),
        .DB_CYCLES (DB_CYCLES),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .disp_io (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] font [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Reference model: run of identical samples, committed value, newest-first history list,
    // and clocks since reset for the scan position.
    logic [3:0]  run_val;
    int unsigned run_len;
    logic [3:0]  cur;
    logic [3:0]  hist [$];
    int unsigned t_since_rst;
    exp_t        exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at time %0t", nm, act, req, $time);
    endtask

    task automatic model_step(input logic [3:0] sw, input logic frz, input logic rn);
        exp_t        e;
        int unsigned idx;
        if (!rn) begin
            run_val     = 4'h0;
            run_len     = 2;
            cur         = 4'h0;
            hist.delete();
            t_since_rst = 0;
            e.csn       = '1;
            e.seg       = 7'b0;
            e.led       = '1;
        end else begin
            idx = (t_since_rst / SCAN_DIV) % DIGITS;
            t_since_rst++;
            e.csn      = '1;
            e.csn[idx] = 1'b0;
            e.seg      = (idx < hist.size()) ? font[hist[idx]] : 7'b0;
            e.led      = (hist.size() > 1) ? ~hist[1] : '1;
            if (run_len >= DB_CYCLES + 1 && run_val != cur) begin
                cur = run_val;
                if (!frz) begin
                    hist.push_front(run_val);
                    if (hist.size() > DIGITS) void'(hist.pop_back());
                end
            end
            if (~sw == run_val) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_val = ~sw;
                run_len = 1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] sw, input int cycles, input logic frz, input logic rn);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            dif.switch = sw;
            dif.freeze = frz;
            resetn     = rn;
            model_step(sw, frz, rn);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("num_csn", 32'(dif.num_csn), 32'(e.csn));
                check("num_a_g", 32'(dif.num_a_g), 32'(e.seg));
                check("led", 32'(dif.led), 32'(e.led));
            end
        end
    end

    initial begin : driver
        logic [3:0] v;
        logic       frz;
        dif.switch = 4'hf;
        dif.freeze = 1'b0;
        resetn     = 1'b0;

        drive(4'hf, 3, 1'b0, 1'b0);
        drive(4'hf, 20, 1'b0, 1'b1);
        // History fill: 8, 9, e, 2 then 0 pushes the oldest entry out.
        drive(4'h8, 10, 1'b0, 1'b1);
        drive(4'h9, 10, 1'b0, 1'b1);
        drive(4'he, 10, 1'b0, 1'b1);
        drive(4'h2, 10, 1'b0, 1'b1);
        drive(4'h0, 10, 1'b0, 1'b1);
        // Short glitches around the debounce length, then a held value.
        drive(4'h8, 10, 1'b0, 1'b1);
        drive(4'h0, 2, 1'b0, 1'b1);
        drive(4'h8, 6, 1'b0, 1'b1);
        drive(4'h0, 3, 1'b0, 1'b1);
        drive(4'h8, 6, 1'b0, 1'b1);
        drive(4'h0, 6, 1'b0, 1'b1);
        // Freeze: the 9 commit updates cur but never reaches the history.
        drive(4'h8, 10, 1'b0, 1'b1);
        drive(4'h9, 10, 1'b1, 1'b1);
        drive(4'he, 10, 1'b0, 1'b1);
        // One-clock reset with a full history.
        drive(4'h3, 10, 1'b0, 1'b1);
        drive(4'h3, 1, 1'b0, 1'b0);
        drive(4'h3, 12, 1'b0, 1'b1);
        drive(4'h5, 10, 1'b0, 1'b1);

        frz = 1'b0;
        for (int s = 0; s < 400; s++) begin
            v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) frz = ~frz;
            if ($urandom_range(0, 79) == 0) drive(v, 1, frz, 1'b0);
            drive(v, int'($urandom_range(1, 2 * DB_CYCLES + 2)), frz, 1'b1);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_hist_disp.md
# sw_hist_disp

Parametrised switch-history display: samples an active-low switch bank, debounces it, and keeps a DIGITS-deep history of committed values. The history is shown newest-first on a scanned, multiplexed 7-segment display. The LED bank shows the previous committed value. It sits between the board switch pins and the board display/LED pins, and generalises the single-digit switch display with a configurable width, depth, debounce, scan rate and a freeze mode.

## Interface
- SW_W, 4: switch/value width, 1..4; values are zero-extended to 4 bits for hex display.
- DIGITS, 4: number of 7-seg digits, which is also the history depth; ≥2.
- DB_CYCLES, 4: debounce length in clocks; ≥1.
- SCAN_DIV, 1000: clocks per digit during the scan; ≥1.
- clk  input  1  system clock.
- resetn  input  1  synchronous, active-low reset; one clock domain.
- switch  input  SW_W  raw switches, active-low (pressed = 0).
- freeze  input  1  1 = hold history/LEDs; commits are not recorded.
- num_csn  output  DIGITS  digit select, active-low one-hot.
- num_a_g  output  7  segments, active-high; bit6 = a … bit0 = g.
- led  output  SW_W  previous committed value, active-low LEDs.

## Operation
- Sample register: sw_n <= ~switch on every clock.
- Debounce state:
  - cand (SW_W bits) and a saturating counter dcnt, width clog2(DB_CYCLES+1).
  - If sw_n != cand: cand <= sw_n, dcnt <= 0.
  - Else if dcnt < DB_CYCLES-1: dcnt increments.
- Commit condition:
  - Requires cand == sw_n, dcnt == DB_CYCLES-1 and cand != cur.
  - On commit, cur <= cand.
  - Equal values never commit.
  - A value that changes and returns to cur before debounce completes does not commit.
- History:
  - hist[0..DIGITS-1] of 4 bits each, with valid bits hv[i].
  - On commit with freeze == 0: hist[0] <= cand, hv[0] <= 1, hist[i] <= hist[i-1], hv[i] <= hv[i-1].
  - The oldest entry is discarded.
- Freeze behaviour:
  - On commit with freeze == 1, cur still updates but hist/hv are unchanged.
  - No catch-up on freeze release.
- Scan:
  - scnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, scnt returns to 0 and idx advances 0→1→…→DIGITS-1→0.
- Registered outputs, updated every clock:
  - num_csn <= ~(1<<idx).
  - num_a_g <= hv[idx] ? seg(hist[idx]) : 7'b0000000 (invalid digits are blanked).
  - led <= hv[1] ? ~hist[1][SW_W-1:0] : all 1s.
- Hex font for seg(): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.

## Timing
- Reset (resetn == 0 at a clock edge) values:
  - sw_n, cand, dcnt, cur, hist, hv, scnt, idx are all 0.
  - num_csn = all 1s (dark), num_a_g = 0, led = all 1s (off).
- Reset priority and mid-operation reset:
  - Reset wins over every other event.
  - Asserting resetn low mid-operation for one edge clears all history; the display goes blank after release.
- Commit latency: if switch holds a new stable value sampled at edge k, cur/hist update at edge k+DB_CYCLES+1.
  - With DB_CYCLES = 1 this is 2 edges.
- Display latency:
  - num_a_g/led reflect hist one clock after the hist update, when that digit is selected.
  - The first post-reset edge drives num_csn = ~1 (digit 0).
- Glitch filtering: any sw_n change restarts debounce, so a glitch shorter than DB_CYCLES clocks is filtered.
- Simultaneous events:
  - A commit coinciding with an idx advance uses the pre-edge hist for that edge's num_a_g.
  - A freeze change and a commit at the same edge use the freeze value sampled at that edge.
- Wrap-around:
  - idx wraps at DIGITS-1.
  - The history shift discards hist[DIGITS-1].
  - dcnt saturates and never wraps.

## Test plan
- Reset, then release with switch = 4'hf (all up):
  - num_csn cycles 4'b1110, 4'b1101, 4'b1011, 4'b0111 every SCAN_DIV clocks.
  - num_a_g = 0 throughout; led = 4'hf; no commits.
- DB_CYCLES=1, SCAN_DIV=1; apply switch = 4'h8, held:
  - At edge k+2, hist[0] = 7 and hv = 4'b0001.
  - On digit 0, num_a_g = 7'b1110000; led stays 4'hf.
- Sequence 8, 9, e, 2, each held 10 clocks:
  - History is {d,1,6,7} with digit 0 = d (num_a_g = 7'b0111101).
  - led = ~1 = 4'he.
  - Continuing with switch = 4'h0 shifts in F (7'b1000111) and drops 7.
- DB_CYCLES=4, cur = 7:
  - A 2-clock pulse switch 4'h8 → 4'h0 → 4'h8 produces no commit.
  - A 4'h0 held 6 clocks commits F.
  - Toggling away and back to 8 within 3 clocks produces no commit.
- freeze = 1 with cur = 7, then switch 4'h9:
  - cur = 6, but hist/led/segments are unchanged.
  - Drop freeze, apply switch 4'he: hist[0] = 1, hist[1] = 7 (6 never recorded).
- History full with DIGITS=4 and resetn pulsed low one clock:
  - Next edge shows num_csn = 4'hf, num_a_g = 0, led = 4'hf.
  - After release, all digits are blank until a new commit.
